ber_error_accumulator: RTL and testbench

Parametrised, clocked successor to the combinational word comparator in the error-checker path. Each cycle it accepts a received word and its reference word under a valid strobe. It registers the per-bit error mask and the per-word error count, and accumulates bit-error, bit and errored-word totals over a programmable measurement window. The totals feed the BER computation and reporting logic downstream.

---
 rtl/ber_error_accumulator_if.sv | 36 +++
 rtl/ber_error_accumulator.sv | 122 ++++++++++++
 tb/tb_ber_error_accumulator.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ber_error_accumulator_if.sv
// Bundles the word stream, measurement control and result signals of the
// BER error accumulator so that producer and consumer share one port.
interface ber_error_accumulator_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 32,
    parameter int WIN_W = 16
);
    localparam int WE_W = $clog2(WIDTH + 1);

    logic                 start;
    logic                 stop;
    logic [WIN_W-1:0]     window_len;
    logic                 valid_in;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [WIDTH-1:0]     error;
    logic [WE_W-1:0]      word_errors;
    logic [CNT_W-1:0]     bit_err_count;
    logic [CNT_W-1:0]     bit_count;
    logic [CNT_W-1:0]     err_word_count;
    logic                 busy;
    logic                 done;
    logic                 sat;

    modport master (
        output start, stop, window_len, valid_in, A, B,
        input  error, word_errors, bit_err_count, bit_count, err_word_count,
               busy, done, sat
    );

    modport slave (
        input  start, stop, window_len, valid_in, A, B,
        output error, word_errors, bit_err_count, bit_count, err_word_count,
               busy, done, sat
    );
endinterface

// File: rtl/ber_error_accumulator.sv
// Registers the per-word XOR error mask and popcount, and accumulates
// saturating bit-error, bit and errored-word totals over a measurement window.
module ber_error_accumulator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 32,
    parameter int WIN_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    ber_error_accumulator_if.slave bus
);
    localparam int WE_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W:0] WIDTH_EXT = (CNT_W + 1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] errorMask_q;
    logic [WE_W-1:0]  wordErrors_q;
    logic [CNT_W-1:0] bitErrCnt_q;
    logic [CNT_W-1:0] bitCnt_q;
    logic [CNT_W-1:0] errWordCnt_q;
    logic             sat_q;
    logic             busy_q;
    logic             done_q;
    logic [WIN_W-1:0] winLen_q;
    logic [WIN_W-1:0] wordCnt_q;

    logic [WIDTH-1:0] xorWord;
    logic [WE_W-1:0]  popCnt;
    logic [CNT_W:0]   bitErrSum;
    logic [CNT_W:0]   bitSum;
    logic [CNT_W:0]   errWordSum;
    logic [CNT_W-1:0] bitErrCnt_d;
    logic [CNT_W-1:0] bitCnt_d;
    logic [CNT_W-1:0] errWordCnt_d;
    logic             sat_d;
    logic [WIN_W:0]   nextWordCnt;
    logic             lastWord;

    always_comb begin
        xorWord = bus.A ^ bus.B;
        popCnt  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            popCnt = popCnt + WE_W'(xorWord[i]);
        end
    end

    // The carry-out of each one-bit-wider sum flags an overflow; the counter
    // then clamps at all-ones instead of wrapping.
    always_comb begin
        bitErrSum    = {1'b0, bitErrCnt_q} + (CNT_W + 1)'(popCnt);
        bitSum       = {1'b0, bitCnt_q} + WIDTH_EXT;
        errWordSum   = {1'b0, errWordCnt_q} + (CNT_W + 1)'(xorWord != '0);
        bitErrCnt_d  = bitErrSum[CNT_W]  ? '1 : bitErrSum[CNT_W-1:0];
        bitCnt_d     = bitSum[CNT_W]     ? '1 : bitSum[CNT_W-1:0];
        errWordCnt_d = errWordSum[CNT_W] ? '1 : errWordSum[CNT_W-1:0];
        sat_d        = sat_q | bitErrSum[CNT_W] | bitSum[CNT_W] | errWordSum[CNT_W];
        nextWordCnt  = {1'b0, wordCnt_q} + 1'b1;
        lastWord     = (winLen_q != '0) && (nextWordCnt == {1'b0, winLen_q});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            errorMask_q  <= '0;
            wordErrors_q <= '0;
            bitErrCnt_q  <= '0;
            bitCnt_q     <= '0;
            errWordCnt_q <= '0;
            sat_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            winLen_q     <= '0;
            wordCnt_q    <= '0;
        end else begin
            if (bus.valid_in) begin
                errorMask_q  <= xorWord;
                wordErrors_q <= popCnt;
            end
            // A start from any state, including mid-run, opens a fresh window;
            // a word arriving alongside it is deliberately not counted.
            if (bus.start) begin
                state_q      <= RUN;
                bitErrCnt_q  <= '0;
                bitCnt_q     <= '0;
                errWordCnt_q <= '0;
                sat_q        <= 1'b0;
                winLen_q     <= bus.window_len;
                wordCnt_q    <= '0;
                busy_q       <= 1'b1;
                done_q       <= 1'b0;
            end else if (state_q == RUN) begin
                if (bus.valid_in) begin
                    bitErrCnt_q  <= bitErrCnt_d;
                    bitCnt_q     <= bitCnt_d;
                    errWordCnt_q <= errWordCnt_d;
                    sat_q        <= sat_d;
                    wordCnt_q    <= nextWordCnt[WIN_W-1:0];
                end
                if (bus.stop || (bus.valid_in && lastWord)) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.error          = errorMask_q;
    assign bus.word_errors    = wordErrors_q;
    assign bus.bit_err_count  = bitErrCnt_q;
    assign bus.bit_count      = bitCnt_q;
    assign bus.err_word_count = errWordCnt_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.sat            = sat_q;
endmodule

// File: tb/tb_ber_error_accumulator.sv
// Scoreboard bench for ber_error_accumulator: a 32-bit-counter instance for the
// window behaviour and a 4-bit-counter instance for saturation.
module tb_ber_error_accumulator;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   assertCount = 0;
    int   failCount = 0;

    always #5 clock = ~clock;

    ber_error_accumulator_if #(.WIDTH(8), .CNT_W(32), .WIN_W(16)) bus ();
    ber_error_accumulator_if #(.WIDTH(8), .CNT_W(4),  .WIN_W(16)) satBus ();

    ber_error_accumulator #(.WIDTH(8), .CNT_W(32), .WIN_W(16)) dut (
        .clk(clock), .rst(reset), .bus(bus.slave)
    );
    ber_error_accumulator #(.WIDTH(8), .CNT_W(4), .WIN_W(16)) satDut (
        .clk(clock), .rst(reset), .bus(satBus.slave)
    );

    typedef struct {
        logic [7:0] err;
        logic [3:0] we;
    } wordExp_t;

    typedef struct {
        logic [31:0] bitErr;
        logic [31:0] bits;
        logic [31:0] errWords;
        logic        sat;
    } finalExp_t;

    wordExp_t  wordQ[$];
    finalExp_t finalQ[$];
    wordExp_t  wordExp;
    finalExp_t finalExp;
    logic      wordTaken = 1'b0;
    logic      prevDone = 1'b0;

    logic [7:0] vecA [5] = '{8'd8, 8'd100, 8'd250, 8'h00, 8'hFB};
    logic [7:0] vecB [5] = '{8'd7, 8'd120, 8'd250, 8'hFB, 8'hFB};
    logic [3:0] vecWe[5] = '{4'd4, 4'd3, 4'd0, 4'd7, 4'd0};

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle on the main instance; any valid word queues its expected monitor value.
    task automatic applyStimulus(input logic st, input logic sp, input logic [15:0] wl,
                                 input logic v, input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] we);
        bus.start      = st;
        bus.stop       = sp;
        bus.window_len = wl;
        bus.valid_in   = v;
        bus.A          = a;
        bus.B          = b;
        if (v) wordQ.push_back(wordExp_t'{a ^ b, we});
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.valid_in = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pushFinal(input logic [31:0] be, input logic [31:0] bc,
                             input logic [31:0] ew, input logic s);
        finalQ.push_back(finalExp_t'{be, bc, ew, s});
    endtask

    task automatic waitDone(input int maxCycles);
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.valid_in = 1'b0;
        for (int i = 0; i < maxCycles && finalQ.size() != 0; i++) @(posedge clock);
        #1;
        checkOutput("done arrival (pending results)", finalQ.size(), 0);
    endtask

    task automatic satStep(input logic st, input logic sp, input logic v,
                           input logic [7:0] a, input logic [7:0] b);
        satBus.start    = st;
        satBus.stop     = sp;
        satBus.valid_in = v;
        satBus.A        = a;
        satBus.B        = b;
        @(posedge clock);
        #1;
    endtask

    task automatic checkMainCounters(input string tag, input logic [31:0] be,
                                     input logic [31:0] bc, input logic [31:0] ew);
        checkOutput({tag, " bit_err_count"}, bus.bit_err_count, be);
        checkOutput({tag, " bit_count"}, bus.bit_count, bc);
        checkOutput({tag, " err_word_count"}, bus.err_word_count, ew);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " error"}, bus.error, 0);
        checkOutput({tag, " word_errors"}, bus.word_errors, 0);
        checkMainCounters(tag, 0, 0, 0);
        checkOutput({tag, " busy"}, bus.busy, 0);
        checkOutput({tag, " done"}, bus.done, 0);
        checkOutput({tag, " sat"}, bus.sat, 0);
        checkOutput({tag, " satDut bit_err_count"}, satBus.bit_err_count, 0);
        checkOutput({tag, " satDut busy"}, satBus.busy, 0);
        checkOutput({tag, " satDut sat"}, satBus.sat, 0);
    endtask

    always @(posedge clock) wordTaken <= bus.valid_in && !reset;

    // Monitor: pops the word scoreboard one cycle after each accepted word and the
    // totals scoreboard on every rising done.
    always @(negedge clock) begin
        if (wordTaken) begin
            if (wordQ.size() == 0) begin
                checkOutput("word scoreboard underflow", 1, 0);
            end else begin
                wordExp = wordQ.pop_front();
                checkOutput("error", bus.error, wordExp.err);
                checkOutput("word_errors", bus.word_errors, wordExp.we);
            end
        end
        if (bus.done && !prevDone) begin
            if (finalQ.size() == 0) begin
                checkOutput("unexpected done", 1, 0);
            end else begin
                finalExp = finalQ.pop_front();
                checkOutput("final bit_err_count", bus.bit_err_count, finalExp.bitErr);
                checkOutput("final bit_count", bus.bit_count, finalExp.bits);
                checkOutput("final err_word_count", bus.err_word_count, finalExp.errWords);
                checkOutput("final sat", bus.sat, finalExp.sat);
                checkOutput("final busy", bus.busy, 0);
            end
        end
        if (bus.busy && bus.done) checkOutput("busy and done exclusive", 1, 0);
        prevDone = bus.done;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        bus.start = 0; bus.stop = 0; bus.window_len = 0; bus.valid_in = 0; bus.A = 0; bus.B = 0;
        satBus.start = 0; satBus.stop = 0; satBus.window_len = 0; satBus.valid_in = 0;
        satBus.A = 0; satBus.B = 0;

        // Reset held while inputs toggle
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            bus.start = 1'($urandom_range(0, 1));
            bus.valid_in = 1'b1;
            bus.A = 8'($urandom);
            bus.B = 8'($urandom);
            bus.window_len = 16'($urandom_range(1, 9));
            satBus.start = 1'b1;
            satBus.valid_in = 1'b1;
            satBus.A = 8'hFF;
        end
        @(negedge clock);
        checkAllZero("reset");
        bus.start = 0; bus.valid_in = 0; bus.window_len = 0;
        satBus.start = 0; satBus.valid_in = 0; satBus.A = 0;
        reset = 1'b0;

        // Window of five back-to-back words
        pushFinal(14, 40, 3, 0);
        applyStimulus(1, 0, 16'd5, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("busy after start", bus.busy, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, vecA[i], vecB[i], vecWe[i]);
        waitDone(4);

        // Same window with 3-cycle gaps, started from DONE
        pushFinal(14, 40, 3, 0);
        applyStimulus(1, 0, 16'd5, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("start in DONE busy", bus.busy, 1);
        checkOutput("start in DONE done", bus.done, 0);
        checkMainCounters("start in DONE", 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, vecA[i], vecB[i], vecWe[i]);
            idle(3);
        end
        checkOutput("gapped done before 5th word", bus.done, 0);
        applyStimulus(0, 0, 0, 1, vecA[4], vecB[4], vecWe[4]);
        waitDone(4);

        // Free-running, stopped together with an 11th valid word
        pushFinal(88, 88, 11, 0);
        applyStimulus(1, 0, 16'd0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1, 8'h00, 8'hFF, 4'd8);
        @(negedge clock);
        checkOutput("free-run still busy", bus.busy, 1);
        applyStimulus(0, 1, 0, 1, 8'h00, 8'hFF, 4'd8);
        waitDone(4);

        // Restart mid-run with a new window length
        applyStimulus(1, 0, 16'd4, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 8'h0F, 8'h00, 4'd4);
        applyStimulus(0, 0, 0, 1, 8'h0F, 8'h00, 4'd4);
        @(negedge clock);
        checkMainCounters("before restart", 8, 16, 2);
        applyStimulus(1, 0, 16'd3, 1, 8'hFF, 8'h00, 4'd8);
        @(negedge clock);
        checkMainCounters("after restart", 0, 0, 0);
        checkOutput("after restart busy", bus.busy, 1);
        pushFinal(3, 24, 2, 0);
        applyStimulus(0, 0, 0, 1, 8'h01, 8'h00, 4'd1);
        applyStimulus(0, 0, 0, 1, 8'h03, 8'h00, 4'd2);
        applyStimulus(0, 0, 0, 1, 8'h00, 8'h00, 4'd0);
        waitDone(4);

        // Asynchronous reset in the middle of a run
        applyStimulus(1, 0, 16'd0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 8'hAA, 8'h55, 4'd8);
        applyStimulus(0, 0, 0, 1, 8'h01, 8'h00, 4'd1);
        idle(1);
        checkMainCounters("pre-reset", 9, 16, 2);
        reset = 1'b1;
        #1;
        checkAllZero("mid-run reset");
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 1, 8'h0F, 8'hF0, 4'd8);
        @(negedge clock);
        checkMainCounters("idle after reset", 0, 0, 0);
        checkOutput("idle after reset busy", bus.busy, 0);
        idle(1);

        // Saturation with 4-bit counters
        satStep(1, 0, 0, 0, 0);
        satStep(0, 0, 1, 8'hFF, 8'h00);
        @(negedge clock);
        checkOutput("sat word1 bit_err_count", satBus.bit_err_count, 8);
        checkOutput("sat word1 sat", satBus.sat, 0);
        satStep(0, 0, 1, 8'hFF, 8'h00);
        @(negedge clock);
        checkOutput("sat word2 bit_err_count", satBus.bit_err_count, 15);
        checkOutput("sat word2 bit_count", satBus.bit_count, 15);
        checkOutput("sat word2 sat", satBus.sat, 1);
        satStep(0, 0, 1, 8'hFF, 8'h00);
        satStep(0, 1, 0, 0, 0);
        @(negedge clock);
        checkOutput("sat stop bit_err_count", satBus.bit_err_count, 15);
        checkOutput("sat stop err_word_count", satBus.err_word_count, 3);
        checkOutput("sat stop sat sticky", satBus.sat, 1);
        checkOutput("sat stop done", satBus.done, 1);
        satStep(1, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("sat restart bit_err_count", satBus.bit_err_count, 0);
        checkOutput("sat restart bit_count", satBus.bit_count, 0);
        checkOutput("sat restart sat", satBus.sat, 0);
        checkOutput("sat restart busy", satBus.busy, 1);
        satStep(0, 0, 0, 0, 0);

        @(negedge clock);
        checkOutput("word scoreboard drained", wordQ.size(), 0);
        checkOutput("totals scoreboard drained", finalQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
